// File: rtl/nibble_compare_seq.sv
// Multi-cycle unsigned magnitude comparator: one 4-bit compare slice reused per clock,
// MSB nibble first, result in {gt,lt,eq} cascade code with a start/busy/done handshake.
module nibble_compare_seq #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int NIB       = WIDTH / 4,
    localparam int CW        = $clog2(NIB + 1)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData,
    output logic [CW-1:0]    oNibbles
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_GT   = 2'd1,
        DEC_LT   = 2'd2
    } decT;

    stateT            stateReg, stateNext;
    decT              decReg, decNext;
    logic [WIDTH-1:0] aReg, aNext;
    logic [WIDTH-1:0] bReg, bNext;
    logic [2:0]       cascReg, cascNext;
    logic [IW-1:0]    idxReg, idxNext;
    logic [CW-1:0]    cntReg, cntNext;
    logic [2:0]       resultReg, resultNext;
    logic [CW-1:0]    nibReg, nibNext;

    logic [3:0]       aNib [NIB];
    logic [3:0]       bNib [NIB];
    logic [3:0]       na;
    logic [3:0]       nb;
    logic             decidedNow;

    // Split the captured operands into nibble lanes for the shared slice.
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : gNib
            assign aNib[gi] = aReg[4*gi +: 4];
            assign bNib[gi] = bReg[4*gi +: 4];
        end
    endgenerate

    assign na = aNib[idxReg];
    assign nb = bNib[idxReg];

    function automatic logic [2:0] decCode(input decT d, input logic [2:0] casc);
        case (d)
            DEC_GT:  decCode = 3'b100;
            DEC_LT:  decCode = 3'b010;
            default: decCode = casc;
        endcase
    endfunction

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateReg  <= IDLE;
            decReg    <= DEC_NONE;
            aReg      <= '0;
            bReg      <= '0;
            cascReg   <= '0;
            idxReg    <= '0;
            cntReg    <= '0;
            resultReg <= 3'b001;
            nibReg    <= '0;
        end else begin
            stateReg  <= stateNext;
            decReg    <= decNext;
            aReg      <= aNext;
            bReg      <= bNext;
            cascReg   <= cascNext;
            idxReg    <= idxNext;
            cntReg    <= cntNext;
            resultReg <= resultNext;
            nibReg    <= nibNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        decNext    = decReg;
        aNext      = aReg;
        bNext      = bReg;
        cascNext   = cascReg;
        idxNext    = idxReg;
        cntNext    = cntReg;
        resultNext = resultReg;
        nibNext    = nibReg;
        decidedNow = 1'b0;

        case (stateReg)
            IDLE: begin
                if (iStart) begin
                    aNext     = iData_a;
                    bNext     = iData_b;
                    cascNext  = iData;
                    idxNext   = IW'(NIB - 1);
                    cntNext   = '0;
                    decNext   = DEC_NONE;
                    stateNext = RUN;
                end
            end
            RUN: begin
                cntNext = cntReg + CW'(1);
                // The first unequal nibble from the top decides; later ones never override.
                if (decReg == DEC_NONE) begin
                    if (na > nb) begin
                        decNext    = DEC_GT;
                        decidedNow = 1'b1;
                    end else if (na < nb) begin
                        decNext    = DEC_LT;
                        decidedNow = 1'b1;
                    end
                end
                if ((EARLY_EXIT && decidedNow) || (idxReg == '0)) begin
                    resultNext = decCode(decNext, cascReg);
                    nibNext    = cntReg + CW'(1);
                    stateNext  = DONE;
                end else begin
                    idxNext = idxReg - IW'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign oBusy    = (stateReg == RUN) || (stateReg == DONE);
    assign oDone    = (stateReg == DONE);
    assign oData    = resultReg;
    assign oNibbles = nibReg;

endmodule

// File: tb/tb_nibble_compare_seq.sv
// Randomised self-checking bench for nibble_compare_seq: an early-exit and a full-scan
// instance share stimulus and are checked against a whole-operand reference model.
module tb_nibble_compare_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dataA;
    logic [15:0] dataB;
    logic [2:0]  casc;

    logic        busyE, doneE, busyF, doneF;
    logic [2:0]  dataOutE, dataOutF;
    logic [2:0]  nibE, nibF;

    int checks;
    int errors;

    nibble_compare_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dutE (
        .iClk(clk), .iRst(rst), .iStart(start),
        .iData_a(dataA), .iData_b(dataB), .iData(casc),
        .oBusy(busyE), .oDone(doneE), .oData(dataOutE), .oNibbles(nibE)
    );

    nibble_compare_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dutF (
        .iClk(clk), .iRst(rst), .iStart(start),
        .iData_a(dataA), .iData_b(dataB), .iData(casc),
        .oBusy(busyF), .oDone(doneF), .oData(dataOutF), .oNibbles(nibF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result from whole-operand comparison; latency from the length of the equal prefix.
    function automatic void refModel(input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] c, input bit early,
                                     output logic [2:0] code, output int k);
        if (a > b)      code = 3'b100;
        else if (a < b) code = 3'b010;
        else            code = c;
        k = 4;
        if (early && a != b) begin
            k = 1;
            for (int j = 1; j <= 3; j++)
                if ((a >> (16 - 4*j)) == (b >> (16 - 4*j))) k = j + 1;
        end
    endfunction

    function automatic logic [15:0] mkB(input logic [15:0] a);
        logic [15:0] r;
        case ($urandom_range(0, 3))
            0:       r = a;
            1:       r = 16'($urandom);
            2:       r = a ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
            default: r = a + 16'($urandom_range(0, 2)) - 16'd1;
        endcase
        return r;
    endfunction

    // Drives one start and observes the result; latency 99 marks a missing oDone.
    task automatic runTxn(input bit useFull, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] c, output int lat, output logic [2:0] data,
                          output logic [2:0] nib, output bit pulseOk);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((useFull ? busyF : busyE) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        dataA = a;
        dataB = b;
        casc  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dataA = 16'($urandom);
        dataB = 16'($urandom);
        casc  = 3'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(useFull ? doneF : doneE) && lat < 30);
        if (!(useFull ? doneF : doneE)) lat = 99;
        data    = useFull ? dataOutF : dataOutE;
        nib     = useFull ? nibF : nibE;
        pulseOk = useFull ? busyF : busyE;
        @(negedge clk);
        pulseOk = pulseOk && !(useFull ? doneF : doneE) && !(useFull ? busyF : busyE)
                  && ((useFull ? dataOutF : dataOutE) === data);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dataA = '0; dataB = '0; casc = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busyE, doneE, dataOutE, nibE} !== {1'b0, 1'b0, 3'b001, 3'd0}) begin
            errors++;
            $display("FAIL reset_E: got busy=%b done=%b data=%b nib=%0d, expected 0 0 001 0",
                     busyE, doneE, dataOutE, nibE);
        end
        checks++;
        if ({busyF, doneF, dataOutF, nibF} !== {1'b0, 1'b0, 3'b001, 3'd0}) begin
            errors++;
            $display("FAIL reset_F: got busy=%b done=%b data=%b nib=%0d, expected 0 0 001 0",
                     busyF, doneF, dataOutF, nibF);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] aT [6] = '{16'h1234, 16'h8000, 16'h8000, 16'h12A4, 16'h12B4, 16'h0001};
        logic [15:0] bT [6] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h12B4, 16'h12A4, 16'h0000};
        bit          fT [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int          kT [6] = '{4, 1, 4, 3, 3, 4};
        logic [2:0]  dT [6] = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b100, 3'b100};
        int lat; logic [2:0] data, nib; bit ok;
        for (int i = 0; i < 6; i++) begin
            runTxn(fT[i], aT[i], bT[i], 3'b001, lat, data, nib, ok);
            checks++;
            if (lat != kT[i] || data !== dT[i] || nib !== 3'(kT[i]) || !ok) begin
                errors++;
                $display("FAIL directed_%0d: got lat=%0d data=%b nib=%0d pulse=%0b, expected lat=%0d data=%b nib=%0d pulse=1",
                         i, lat, data, nib, ok, kT[i], dT[i], kT[i]);
            end
        end
    endtask

    task automatic test_cascade;
        logic [2:0] cT [4] = '{3'b100, 3'b010, 3'b000, 3'b011};
        int lat; logic [2:0] data, nib; bit ok;
        for (int i = 0; i < 4; i++) begin
            runTxn(1'b0, 16'hFFFF, 16'hFFFF, cT[i], lat, data, nib, ok);
            checks++;
            if (lat != 4 || data !== cT[i] || nib !== 3'd4 || !ok) begin
                errors++;
                $display("FAIL cascade_%b: got lat=%0d data=%b nib=%0d pulse=%0b, expected lat=4 data=%b nib=4",
                         cT[i], lat, data, nib, ok, cT[i]);
            end
        end
    endtask

    task automatic test_random;
        int lat, k; logic [2:0] data, nib, code; bit ok, full;
        logic [15:0] a, b; logic [2:0] c;
        for (int i = 0; i < 30; i++) begin
            full = (i % 3 == 2);
            a = 16'($urandom);
            b = mkB(a);
            c = 3'($urandom);
            refModel(a, b, c, !full, code, k);
            runTxn(full, a, b, c, lat, data, nib, ok);
            checks++;
            if (lat != k || data !== code || nib !== 3'(k) || !ok) begin
                errors++;
                $display("FAIL random_%0d (A=%h B=%h c=%b full=%0b): got lat=%0d data=%b nib=%0d pulse=%0b, expected lat=%0d data=%b nib=%0d",
                         i, a, b, c, full, lat, data, nib, ok, k, code, k);
            end
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 60;
        logic [15:0] aArr [N];
        logic [15:0] bArr [N];
        logic [2:0]  cArr [N];
        int          gotCyc[$], expCyc[$];
        logic [2:0]  gotData[$], gotNib[$], expData[$];
        int          expK[$];
        int acc, k, guard;
        logic [2:0] code;
        guard = 0;
        @(negedge clk);
        while ((busyE || busyF) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int cyc = 0; cyc < N + 12; cyc++) begin
            if (cyc < N) begin
                aArr[cyc] = 16'($urandom);
                bArr[cyc] = mkB(aArr[cyc]);
                cArr[cyc] = 3'($urandom);
                dataA = aArr[cyc]; dataB = bArr[cyc]; casc = cArr[cyc];
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (doneE) begin
                gotCyc.push_back(cyc);
                gotData.push_back(dataOutE);
                gotNib.push_back(nibE);
            end
        end
        acc = 0;
        while (acc < N) begin
            refModel(aArr[acc], bArr[acc], cArr[acc], 1'b1, code, k);
            expCyc.push_back(acc + k);
            expData.push_back(code);
            expK.push_back(k);
            acc += k + 2;
        end
        checks++;
        if (gotCyc.size() != expCyc.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected %0d", gotCyc.size(), expCyc.size());
        end
        for (int i = 0; i < expCyc.size() && i < gotCyc.size(); i++) begin
            checks++;
            if (gotCyc[i] != expCyc[i] || gotData[i] !== expData[i] || gotNib[i] !== 3'(expK[i])) begin
                errors++;
                $display("FAIL b2b_%0d: got cyc=%0d data=%b nib=%0d, expected cyc=%0d data=%b nib=%0d",
                         i, gotCyc[i], gotData[i], gotNib[i], expCyc[i], expData[i], expK[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [2:0] data, nib; bit ok, sawDone;
        runTxn(1'b0, 16'h9000, 16'h1000, 3'b001, lat, data, nib, ok);
        @(negedge clk);
        dataA = 16'h5555; dataB = 16'h5555; casc = 3'b011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busyE !== 1'b1 || doneE !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_running: got busy=%b done=%b, expected 1 0", busyE, doneE);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busyE, doneE, dataOutE, nibE} !== {1'b0, 1'b0, 3'b001, 3'd0}) begin
            errors++;
            $display("FAIL rstmid_async: got busy=%b done=%b data=%b nib=%0d, expected 0 0 001 0",
                     busyE, doneE, dataOutE, nibE);
        end
        sawDone = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sawDone = sawDone | doneE;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nodone: got oDone after reset, expected none");
        end
        runTxn(1'b0, 16'h00F0, 16'h0F00, 3'b001, lat, data, nib, ok);
        checks++;
        if (lat != 2 || data !== 3'b010 || nib !== 3'd2 || !ok) begin
            errors++;
            $display("FAIL rstmid_fresh: got lat=%0d data=%b nib=%0d pulse=%0b, expected lat=2 data=010 nib=2",
                     lat, data, nib, ok);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_cascade();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
